ps2_keymap_scanner: RTL and testbench

- Parametrised successor to the team's fixed 4-key PS/2 keyboard driver.
- Decodes PS/2 keyboard frames entirely in the `clk` domain; no logic is clocked by `ps2_clk`.
- Adds over the fixed driver: a programmable key table with E0 extended-code support, parity/stop/timeout error detection with resynchronisation, and press/release event pulses.
- Sits between the board PS/2 pins and game control logic; `keys` feeds movement/restart inputs directly.

---
 rtl/ps2_keymap_scanner.sv | 183 ++++++++++++++++++
 tb/tb_ps2_keymap_scanner.sv | 214 +++++++++++++++++++++
 2 files changed

// File: rtl/ps2_keymap_scanner.sv
// PS/2 keyboard frame receiver with glitch filtering, error detection and a
// programmable key table (E0 extended codes) driving held-key levels and events.
module ps2_keymap_scanner #(
   parameter int unsigned             NUM_KEYS    = 4,
   parameter logic [9*NUM_KEYS-1:0]   KEY_CODES   = {9'h02D, 9'h01C, 9'h023, 9'h01D},
   parameter int unsigned             FILTER_LEN  = 8,
   parameter int unsigned             TIMEOUT_CYC = 200000,
   localparam int unsigned            IDXW        = (NUM_KEYS > 1) ? $clog2(NUM_KEYS) : 1
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic                ps2_clk,
   input  logic                ps2_data,
   output logic [NUM_KEYS-1:0] keys,
   output logic                key_event,
   output logic [IDXW-1:0]     key_event_idx,
   output logic                key_event_make,
   output logic                scan_valid,
   output logic [7:0]          scan_code,
   output logic                frame_err
);

   localparam int unsigned TCW = $clog2(TIMEOUT_CYC + 1);

   typedef enum logic [1:0] {S_IDLE, S_DATA, S_PARITY, S_STOP} state_t;

   state_t                r_state, w_state_nxt;
   logic [1:0]            r_clk_sync, r_dat_sync;
   logic [FILTER_LEN-1:0] r_clk_sh, r_dat_sh;
   logic                  r_fc, r_fd, r_fc_prev;
   logic [2:0]            r_bitcnt;
   logic [7:0]            r_shift;
   logic                  r_par;
   logic [TCW-1:0]        r_tcnt;
   logic                  r_ext, r_brk;
   logic [NUM_KEYS-1:0]   r_keys;
   logic                  r_key_event, r_key_make, r_scan_valid, r_frame_err;
   logic [IDXW-1:0]       r_key_idx;
   logic [7:0]            r_scan_code;

   logic                  w_fall, w_timeout;
   logic                  w_start, w_shift_en, w_par_en, w_frame_ok, w_frame_bad;
   logic                  w_hit;
   logic [IDXW-1:0]       w_hit_idx;

   // Synchronise then require FILTER_LEN agreeing samples before the filtered level moves
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_clk_sync <= 2'b11;
         r_dat_sync <= 2'b11;
         r_clk_sh   <= '1;
         r_dat_sh   <= '1;
         r_fc       <= 1'b1;
         r_fd       <= 1'b1;
         r_fc_prev  <= 1'b1;
      end else begin
         r_clk_sync <= {r_clk_sync[0], ps2_clk};
         r_dat_sync <= {r_dat_sync[0], ps2_data};
         r_clk_sh   <= {r_clk_sh[FILTER_LEN-2:0], r_clk_sync[1]};
         r_dat_sh   <= {r_dat_sh[FILTER_LEN-2:0], r_dat_sync[1]};
         if (&r_clk_sh)       r_fc <= 1'b1;
         else if (~|r_clk_sh) r_fc <= 1'b0;
         if (&r_dat_sh)       r_fd <= 1'b1;
         else if (~|r_dat_sh) r_fd <= 1'b0;
         r_fc_prev  <= r_fc;
      end
   end

   assign w_fall    = r_fc_prev & ~r_fc;
   assign w_timeout = (r_state != S_IDLE) && !w_fall && (r_tcnt == TCW'(TIMEOUT_CYC - 1));

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) r_state <= S_IDLE;
      else        r_state <= w_state_nxt;
   end

   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         S_IDLE:   if (w_fall && !r_fd)                 w_state_nxt = S_DATA;
         S_DATA:   if (w_fall && (r_bitcnt == 3'd7))    w_state_nxt = S_PARITY;
         S_PARITY: if (w_fall)                          w_state_nxt = S_STOP;
         S_STOP:   if (w_fall)                          w_state_nxt = S_IDLE;
         default:                                       w_state_nxt = S_IDLE;
      endcase
      if (w_timeout) w_state_nxt = S_IDLE;
   end

   always_comb begin
      w_start     = 1'b0;
      w_shift_en  = 1'b0;
      w_par_en    = 1'b0;
      w_frame_ok  = 1'b0;
      w_frame_bad = w_timeout;
      case (r_state)
         S_IDLE:   w_start    = w_fall && !r_fd;
         S_DATA:   w_shift_en = w_fall;
         S_PARITY: w_par_en   = w_fall;
         S_STOP: begin
            // Odd parity: data bits and parity bit together hold an odd count of ones
            w_frame_ok  = w_fall && r_fd && (^{r_par, r_shift});
            w_frame_bad = w_timeout || (w_fall && !(r_fd && (^{r_par, r_shift})));
         end
         default: ;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_bitcnt     <= '0;
         r_shift      <= '0;
         r_par        <= 1'b0;
         r_tcnt       <= '0;
         r_scan_valid <= 1'b0;
         r_scan_code  <= '0;
         r_frame_err  <= 1'b0;
      end else begin
         if (w_fall || r_state == S_IDLE) r_tcnt <= '0;
         else                             r_tcnt <= r_tcnt + TCW'(1);
         if (w_start)         r_bitcnt <= '0;
         else if (w_shift_en) r_bitcnt <= r_bitcnt + 3'd1;
         if (w_shift_en) r_shift <= {r_fd, r_shift[7:1]};
         if (w_par_en)   r_par   <= r_fd;
         r_scan_valid <= w_frame_ok;
         r_frame_err  <= w_frame_bad;
         if (w_frame_ok) r_scan_code <= r_shift;
      end
   end

   // Lowest matching table index wins
   always_comb begin
      w_hit     = 1'b0;
      w_hit_idx = '0;
      for (int i = int'(NUM_KEYS) - 1; i >= 0; i--) begin
         if (KEY_CODES[9*i +: 9] == {r_ext, r_scan_code}) begin
            w_hit     = 1'b1;
            w_hit_idx = IDXW'(i);
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_ext       <= 1'b0;
         r_brk       <= 1'b0;
         r_keys      <= '0;
         r_key_event <= 1'b0;
         r_key_idx   <= '0;
         r_key_make  <= 1'b0;
      end else begin
         r_key_event <= 1'b0;
         if (r_frame_err) begin
            r_ext <= 1'b0;
            r_brk <= 1'b0;
         end else if (r_scan_valid) begin
            if (r_scan_code == 8'hE0) begin
               r_ext <= 1'b1;
            end else if (r_scan_code == 8'hF0) begin
               r_brk <= 1'b1;
            end else begin
               r_ext <= 1'b0;
               r_brk <= 1'b0;
               // Typematic repeats of an already-held key produce no event
               if (w_hit && (r_keys[w_hit_idx] != ~r_brk)) begin
                  r_keys[w_hit_idx] <= ~r_brk;
                  r_key_event       <= 1'b1;
                  r_key_idx         <= w_hit_idx;
                  r_key_make        <= ~r_brk;
               end
            end
         end
      end
   end

   assign keys           = r_keys;
   assign key_event      = r_key_event;
   assign key_event_idx  = r_key_idx;
   assign key_event_make = r_key_make;
   assign scan_valid     = r_scan_valid;
   assign scan_code      = r_scan_code;
   assign frame_err      = r_frame_err;

endmodule

// File: tb/tb_ps2_keymap_scanner.sv
// Directed bench for ps2_keymap_scanner: bit-banged PS/2 frames with
// hand-computed key states, event pulses and error pulses.
module tb_ps2_keymap_scanner;

   localparam int unsigned TB_TO = 2000;
   localparam int unsigned HALF  = 20;

   logic       clk;
   logic       rst_n;
   logic       ps2_clk;
   logic       ps2_data;

   logic [3:0] keys,  keys2;
   logic       key_event, ke2;
   logic [1:0] key_event_idx, idx2;
   logic       key_event_make, mk2;
   logic       scan_valid, sv2;
   logic [7:0] scan_code, sc2;
   logic       frame_err, fe2;

   int n_total = 0;
   int n_bad   = 0;
   int n_sv = 0, n_fe = 0, n_ke = 0;
   int b_sv, b_fe, b_ke;
   logic [1:0] last_idx = '0;
   logic       last_make = 1'b0;

   ps2_keymap_scanner #(.TIMEOUT_CYC(TB_TO)) dut (
      .clk(clk), .rst_n(rst_n), .ps2_clk(ps2_clk), .ps2_data(ps2_data),
      .keys(keys), .key_event(key_event), .key_event_idx(key_event_idx),
      .key_event_make(key_event_make), .scan_valid(scan_valid),
      .scan_code(scan_code), .frame_err(frame_err)
   );

   // Key 0 remapped to the extended up-arrow code
   ps2_keymap_scanner #(
      .KEY_CODES({9'h02D, 9'h01C, 9'h023, 9'h175}),
      .TIMEOUT_CYC(TB_TO)
   ) dut_ext (
      .clk(clk), .rst_n(rst_n), .ps2_clk(ps2_clk), .ps2_data(ps2_data),
      .keys(keys2), .key_event(ke2), .key_event_idx(idx2),
      .key_event_make(mk2), .scan_valid(sv2),
      .scan_code(sc2), .frame_err(fe2)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always @(posedge clk) begin
      if (scan_valid) n_sv <= n_sv + 1;
      if (frame_err)  n_fe <= n_fe + 1;
      if (key_event) begin
         n_ke      <= n_ke + 1;
         last_idx  <= key_event_idx;
         last_make <= key_event_make;
      end
   end

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_total++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   task automatic snap();
      b_sv = n_sv;
      b_fe = n_fe;
      b_ke = n_ke;
   endtask

   task automatic ps2_bit(input logic v);
      ps2_data = v;
      repeat (HALF) @(posedge clk);
      ps2_clk = 1'b0;
      repeat (HALF) @(posedge clk);
      ps2_clk = 1'b1;
   endtask

   task automatic send_frame(input logic [7:0] b, input logic bad_par, input logic bad_stop);
      ps2_bit(1'b0);
      for (int i = 0; i < 8; i++) ps2_bit(b[i]);
      ps2_bit((~^b) ^ bad_par);
      ps2_bit(~bad_stop);
      ps2_data = 1'b1;
      repeat (3 * HALF) @(posedge clk);
      @(negedge clk);
   endtask

   initial begin
      #3_000_000;
      $display("FAIL watchdog got=timeout exp=finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      rst_n    = 1'b0;
      ps2_clk  = 1'b1;
      ps2_data = 1'b1;
      repeat (5) @(posedge clk);
      #1;
      check_eq("rst_keys", 32'(keys), 32'h0);
      check_eq("rst_scan_code", 32'(scan_code), 32'h0);
      check_eq("rst_pulses", 32'({key_event, scan_valid, frame_err}), 32'h0);
      check_eq("rst_idx_make", 32'({key_event_idx, key_event_make}), 32'h0);
      rst_n = 1'b1;
      repeat (20) @(posedge clk);

      // Short clock glitches must be filtered out
      snap();
      for (int g = 0; g < 3; g++) begin
         ps2_clk = 1'b0;
         repeat (5) @(posedge clk);
         ps2_clk = 1'b1;
         repeat (30) @(posedge clk);
      end
      @(negedge clk);
      check_eq("glitch_keys", 32'(keys), 32'h0);
      check_eq("glitch_sv", 32'(n_sv - b_sv), 32'h0);
      check_eq("glitch_fe", 32'(n_fe - b_fe), 32'h0);

      // Make, typematic repeat, break
      snap();
      send_frame(8'h1D, 1'b0, 1'b0);
      check_eq("make_scan_code", 32'(scan_code), 32'h1D);
      check_eq("make_sv", 32'(n_sv - b_sv), 32'h1);
      check_eq("make_keys", 32'(keys), 32'h1);
      check_eq("make_ev", 32'(n_ke - b_ke), 32'h1);
      check_eq("make_idx", 32'(last_idx), 32'h0);
      check_eq("make_dir", 32'(last_make), 32'h1);
      snap();
      send_frame(8'h1D, 1'b0, 1'b0);
      check_eq("repeat_ev", 32'(n_ke - b_ke), 32'h0);
      check_eq("repeat_sv", 32'(n_sv - b_sv), 32'h1);
      snap();
      send_frame(8'hF0, 1'b0, 1'b0);
      send_frame(8'h1D, 1'b0, 1'b0);
      check_eq("break_keys", 32'(keys), 32'h0);
      check_eq("break_ev", 32'(n_ke - b_ke), 32'h1);
      check_eq("break_idx", 32'(last_idx), 32'h0);
      check_eq("break_dir", 32'(last_make), 32'h0);

      // Extended code only matches with the E0 prefix
      send_frame(8'h75, 1'b0, 1'b0);
      check_eq("ext_plain", 32'(keys2), 32'h0);
      check_eq("ext_plain_sc", 32'(sc2), 32'h75);
      send_frame(8'hE0, 1'b0, 1'b0);
      send_frame(8'h75, 1'b0, 1'b0);
      check_eq("ext_make", 32'(keys2), 32'h1);
      check_eq("ext_main_untouched", 32'(keys), 32'h0);
      send_frame(8'hE0, 1'b0, 1'b0);
      send_frame(8'hF0, 1'b0, 1'b0);
      send_frame(8'h75, 1'b0, 1'b0);
      check_eq("ext_break", 32'(keys2), 32'h0);

      // Parity and stop errors
      snap();
      send_frame(8'h2D, 1'b1, 1'b0);
      check_eq("par_fe", 32'(n_fe - b_fe), 32'h1);
      check_eq("par_sv", 32'(n_sv - b_sv), 32'h0);
      check_eq("par_keys", 32'(keys), 32'h0);
      snap();
      send_frame(8'h2D, 1'b0, 1'b1);
      check_eq("stop_fe", 32'(n_fe - b_fe), 32'h1);
      check_eq("stop_sv", 32'(n_sv - b_sv), 32'h0);
      send_frame(8'hF0, 1'b0, 1'b0);
      send_frame(8'h2D, 1'b1, 1'b0);
      send_frame(8'h2D, 1'b0, 1'b0);
      check_eq("prefix_cleared", 32'(keys), 32'h8);

      // Stalled frame times out, next frame decodes normally
      snap();
      ps2_bit(1'b0);
      for (int i = 0; i < 4; i++) ps2_bit(1'b1);
      ps2_data = 1'b1;
      repeat (TB_TO + 100) @(posedge clk);
      @(negedge clk);
      check_eq("timeout_fe", 32'(n_fe - b_fe), 32'h1);
      check_eq("timeout_sv", 32'(n_sv - b_sv), 32'h0);
      send_frame(8'h1C, 1'b0, 1'b0);
      check_eq("after_timeout_keys", 32'(keys), 32'hC);

      // Async reset in the middle of a frame
      send_frame(8'h23, 1'b0, 1'b0);
      send_frame(8'h1D, 1'b0, 1'b0);
      check_eq("all_held", 32'(keys), 32'hF);
      ps2_bit(1'b0);
      ps2_bit(1'b1);
      ps2_bit(1'b1);
      ps2_bit(1'b0);
      ps2_bit(1'b0);
      rst_n = 1'b0;
      #1;
      check_eq("midrst_keys", 32'(keys), 32'h0);
      check_eq("midrst_sc", 32'(scan_code), 32'h0);
      check_eq("midrst_pulses", 32'({key_event, scan_valid, frame_err}), 32'h0);
      ps2_data = 1'b1;
      ps2_clk  = 1'b1;
      repeat (10) @(posedge clk);
      rst_n = 1'b1;
      repeat (20) @(posedge clk);
      snap();
      send_frame(8'h23, 1'b0, 1'b0);
      check_eq("post_rst_keys", 32'(keys), 32'h2);
      check_eq("post_rst_ev", 32'(n_ke - b_ke), 32'h1);
      check_eq("post_rst_idx", 32'(last_idx), 32'h1);
      check_eq("post_rst_fe", 32'(n_fe - b_fe), 32'h0);

      $display("test done: total=%0d bad=%0d", n_total, n_bad);
      $finish;
   end

endmodule
